seg_scan_driver: RTL

- Time-multiplexed seven-segment display driver for the led_lights subsystem; sits directly downstream of bin_to_bcd.
- Consumes the per-digit BCD array (code 15 = suppressed/blank digit) and scans it onto a common-anode multi-digit display.
- Adds dead-time between digits against ghosting, per-digit decimal point and blink, and frame-aligned input capture so a changing value never tears mid-frame.

---
 rtl/seg_display_pkg.sv | 28 ++
 rtl/seg7_decoder.sv | 29 ++
 rtl/seg_scan_driver.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/seg_display_pkg.sv
// Shared constants and types for the seven-segment display path.
// Segment patterns are active-high, bit order {g,f,e,d,c,b,a}.
package seg_display_pkg;

  localparam logic [3:0] BCD_BLANK = 4'd15;
  localparam logic [3:0] BCD_MINUS = 4'd10;

  localparam logic [6:0] SEG_0     = 7'b0111111;
  localparam logic [6:0] SEG_1     = 7'b0000110;
  localparam logic [6:0] SEG_2     = 7'b1011011;
  localparam logic [6:0] SEG_3     = 7'b1001111;
  localparam logic [6:0] SEG_4     = 7'b1100110;
  localparam logic [6:0] SEG_5     = 7'b1101101;
  localparam logic [6:0] SEG_6     = 7'b1111101;
  localparam logic [6:0] SEG_7     = 7'b0000111;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1101111;
  localparam logic [6:0] SEG_MINUS = 7'b1000000;
  localparam logic [6:0] SEG_E     = 7'b1111001;
  localparam logic [6:0] SEG_OFF   = 7'b0000000;

  typedef enum logic [1:0] {
    IDLE,
    BLANK,
    SHOW
  } scan_state_e;

endpackage

// File: rtl/seg7_decoder.sv
// Combinational digit code to active-high segment pattern.
// Codes 11-14 render as 'E'; 15 and anything unmapped render dark.
module seg7_decoder
  import seg_display_pkg::*;
(
  input  logic [3:0] code,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_OFF;
    case (code)
      4'd0:                      seg = SEG_0;
      4'd1:                      seg = SEG_1;
      4'd2:                      seg = SEG_2;
      4'd3:                      seg = SEG_3;
      4'd4:                      seg = SEG_4;
      4'd5:                      seg = SEG_5;
      4'd6:                      seg = SEG_6;
      4'd7:                      seg = SEG_7;
      4'd8:                      seg = SEG_8;
      4'd9:                      seg = SEG_9;
      BCD_MINUS:                 seg = SEG_MINUS;
      4'd11, 4'd12, 4'd13, 4'd14: seg = SEG_E;
      default:                   seg = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed common-anode display scanner with per-slot dead time, blink and
// frame-aligned input capture. All pin outputs are registered.
module seg_scan_driver
  import seg_display_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ    = 100_000_000,
  parameter int unsigned SCAN_HZ        = 1000,
  parameter int unsigned NUM_DIGITS     = 4,
  parameter int unsigned BLANK_CYCLES   = 16,
  parameter int unsigned BLINK_HZ       = 2,
  parameter int unsigned SEG_ACTIVE_LOW = 1,
  parameter int unsigned AN_ACTIVE_LOW  = 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            enable,
  input  logic [0:NUM_DIGITS-1][3:0]      bcd_in,
  input  logic [NUM_DIGITS-1:0]           dp_in,
  input  logic [NUM_DIGITS-1:0]           blink_mask,
  output logic [6:0]                      seg_out,
  output logic                            dp_out,
  output logic [NUM_DIGITS-1:0]           an_out,
  output logic                            frame_done
);

  localparam int unsigned DIGIT_PERIOD = CLK_FREQ_HZ / SCAN_HZ;
  localparam int unsigned SHOW_CYCLES  = DIGIT_PERIOD - BLANK_CYCLES;
  localparam int unsigned BLINK_HALF   = CLK_FREQ_HZ / (2 * BLINK_HZ);
  localparam int unsigned SLOT_W  = (DIGIT_PERIOD > 1) ? $clog2(DIGIT_PERIOD) : 1;
  localparam int unsigned BLINK_W = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
  localparam int unsigned DIG_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic SEG_INV = (SEG_ACTIVE_LOW != 0);
  localparam logic AN_INV  = (AN_ACTIVE_LOW != 0);

  scan_state_e                 state_q, state_d;
  logic [DIG_W-1:0]            digit_q, digit_d;
  logic [SLOT_W-1:0]           slot_q, slot_d;
  logic [BLINK_W-1:0]          blink_cnt_q;
  logic                        blink_on_q;
  logic [0:NUM_DIGITS-1][3:0]  shadow_bcd_q;
  logic [NUM_DIGITS-1:0]       shadow_dp_q;
  logic [NUM_DIGITS-1:0]       shadow_blink_q;

  logic                        capture;
  logic                        wrap;
  logic                        blanked;
  logic [3:0]                  seg_code;
  logic                        dp_act;
  logic [NUM_DIGITS-1:0]       an_act;
  logic [6:0]                  seg_pat;

  // A blinking digit keeps its anode slot but renders dark during the off phase.
  assign blanked = ~blink_on_q & shadow_blink_q[digit_q];

  always_comb begin
    state_d  = state_q;
    digit_d  = digit_q;
    slot_d   = slot_q;
    capture  = 1'b0;
    wrap     = 1'b0;
    an_act   = '0;
    seg_code = BCD_BLANK;
    dp_act   = 1'b0;
    if (!enable) begin
      state_d = IDLE;
      digit_d = '0;
      slot_d  = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          capture = 1'b1;
          digit_d = '0;
          slot_d  = '0;
          state_d = BLANK;
        end
        BLANK: begin
          if (slot_q == SLOT_W'(BLANK_CYCLES - 1)) begin
            slot_d  = '0;
            state_d = SHOW;
          end else begin
            slot_d = slot_q + 1'b1;
          end
        end
        SHOW: begin
          an_act[digit_q] = 1'b1;
          seg_code = blanked ? BCD_BLANK : shadow_bcd_q[digit_q];
          dp_act   = shadow_dp_q[digit_q] & ~blanked;
          if (slot_q == SLOT_W'(SHOW_CYCLES - 1)) begin
            slot_d  = '0;
            state_d = BLANK;
            if (digit_q == DIG_W'(NUM_DIGITS - 1)) begin
              digit_d = '0;
              wrap    = 1'b1;
              capture = 1'b1;
            end else begin
              digit_d = digit_q + 1'b1;
            end
          end else begin
            slot_d = slot_q + 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  seg7_decoder u_decoder (
    .code (seg_code),
    .seg  (seg_pat)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      digit_q <= '0;
      slot_q  <= '0;
    end else begin
      state_q <= state_d;
      digit_q <= digit_d;
      slot_q  <= slot_d;
    end
  end

  // Free-running, independent of enable.
  always_ff @(posedge clk) begin
    if (rst) begin
      blink_cnt_q <= '0;
      blink_on_q  <= 1'b1;
    end else if (blink_cnt_q == BLINK_W'(BLINK_HALF - 1)) begin
      blink_cnt_q <= '0;
      blink_on_q  <= ~blink_on_q;
    end else begin
      blink_cnt_q <= blink_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_bcd_q   <= {NUM_DIGITS{BCD_BLANK}};
      shadow_dp_q    <= '0;
      shadow_blink_q <= '0;
    end else if (capture) begin
      shadow_bcd_q   <= bcd_in;
      shadow_dp_q    <= dp_in;
      shadow_blink_q <= blink_mask;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      seg_out    <= {7{SEG_INV}};
      dp_out     <= SEG_INV;
      an_out     <= {NUM_DIGITS{AN_INV}};
      frame_done <= 1'b0;
    end else begin
      seg_out    <= seg_pat ^ {7{SEG_INV}};
      dp_out     <= dp_act ^ SEG_INV;
      an_out     <= an_act ^ {NUM_DIGITS{AN_INV}};
      frame_done <= wrap;
    end
  end

endmodule
